// File: rtl/credit_source.sv
// rtl/credit_source.sv - credit-gated transmit adapter with 2-entry skid buffer
module credit_source #(
    parameter int DATA_WIDTH = 17,
    parameter int N_CREDITS  = 8,
    parameter int CNT_WIDTH  = $clog2(N_CREDITS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_increment_count,
    output logic [CNT_WIDTH-1:0]  o_credits,
    output logic                  o_overflow
);

    localparam logic [CNT_WIDTH-1:0] FULL_CREDITS = CNT_WIDTH'(N_CREDITS);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            buf_count;
    logic [CNT_WIDTH-1:0]  credits;
    logic                  push;
    logic                  send;

    // Ready depends only on occupancy, so upstream never sees a path from credits.
    assign o_ready   = reset && (buf_count < 2'd2);
    assign push      = i_valid && o_ready;
    assign send      = (buf_count != 2'd0) && (credits != '0);
    assign o_credits = credits;

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            buf_count  <= 2'd0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            credits    <= FULL_CREDITS;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (send) begin
                o_data <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            o_valid   <= send;
            buf_count <= buf_count + {1'b0, push} - {1'b0, send};

            // A return with every credit already home is a receiver protocol error.
            if (send && !i_increment_count) begin
                credits <= credits - 1'b1;
            end else if (!send && i_increment_count) begin
                if (credits == FULL_CREDITS) begin
                    o_overflow <= 1'b1;
                end else begin
                    credits <= credits + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_credit_source.sv
// tb/tb_credit_source.sv - randomized self-checking bench for credit_source
module tb_credit_source;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [16:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_increment_count = 1'b0;
    logic        o_ready;
    logic [16:0] o_data;
    logic        o_valid;
    logic [3:0]  o_credits;
    logic        o_overflow;

    int pass_cnt = 0;
    int total = 0;

    logic [16:0] m_q[$];
    int          m_cred = 8;
    bit          m_ovf = 1'b0;
    bit          m_valid = 1'b0;
    logic [16:0] m_data = '0;

    credit_source dut (
        .clock(clock),
        .reset(reset),
        .i_data(i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_data(o_data),
        .o_valid(o_valid),
        .i_increment_count(i_increment_count),
        .o_credits(o_credits),
        .o_overflow(o_overflow)
    );

    always #5 clock = ~clock;

    // Drive one cycle, advance the queue-based reference model, sample #1 after the edge.
    task automatic step(input bit v, input logic [16:0] d, input bit inc, output bit acc);
        bit snd;
        i_valid = v;
        i_data = d;
        i_increment_count = inc;
        acc = reset && v && (m_q.size() < 2);
        @(posedge clock);
        #1;
        if (!reset) begin
            m_q.delete();
            m_cred = 8;
            m_ovf = 1'b0;
            m_valid = 1'b0;
            m_data = '0;
        end else begin
            snd = (m_q.size() > 0) && (m_cred > 0);
            m_valid = snd;
            if (snd) m_data = m_q.pop_front();
            m_cred = m_cred - int'(snd) + int'(inc);
            if (m_cred > 8) begin
                m_cred = 8;
                m_ovf = 1'b1;
            end
            if (acc) m_q.push_back(d);
        end
    endtask

    task automatic apply_reset();
        bit acc;
        reset = 1'b0;
        step(0, '0, 0, acc);
        step(0, '0, 0, acc);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bit acc;
        int n = 0;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(n < 3, 17'($urandom) | 17'h1, 0, acc);
            if (acc) n++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(bit'($urandom % 2), 17'($urandom), bit'($urandom % 2), acc);
            total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", o_valid); else pass_cnt++;
            total++; if (o_data !== 17'h0) $display("FAIL reset_data got %0h exp 0", o_data); else pass_cnt++;
            total++; if (o_credits !== 4'd8) $display("FAIL reset_credits got %0d exp 8", o_credits); else pass_cnt++;
            total++; if (o_ready !== 1'b0) $display("FAIL reset_ready got %0b exp 0", o_ready); else pass_cnt++;
            total++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow got %0b exp 0", o_overflow); else pass_cnt++;
        end
        reset = 1'b1;
        #1;
        total++; if (o_ready !== 1'b1) $display("FAIL reset_release_ready got %0b exp 1", o_ready); else pass_cnt++;
    endtask

    task automatic test_streaming();
        bit acc;
        bit started = 1'b0;
        bit was_streaming;
        int idx = 0;
        int rx = 0;
        logic [2:0] hist = '0;
        apply_reset();
        for (int c = 0; c < 200 && rx < 20; c++) begin
            was_streaming = started && (rx < 20);
            step(idx < 20, 17'(idx + 1), hist[2], acc);
            if (acc) idx++;
            hist = {hist[1:0], o_valid};
            total++; if (o_valid !== m_valid) $display("FAIL stream_valid got %0b exp %0b", o_valid, m_valid); else pass_cnt++;
            if (was_streaming) begin
                total++; if (o_valid !== 1'b1) $display("FAIL stream_bubble got %0b exp 1 at word %0d", o_valid, rx + 1); else pass_cnt++;
            end
            if (o_valid === 1'b1) begin
                total++; if (o_data !== 17'(rx + 1)) $display("FAIL stream_order got %0h exp %0h", o_data, rx + 1); else pass_cnt++;
                rx++;
                started = 1'b1;
            end
            total++; if (o_credits !== 4'(m_cred) || o_credits > 4'd8) $display("FAIL stream_credits got %0d exp %0d", o_credits, m_cred); else pass_cnt++;
        end
        total++; if (rx != 20) $display("FAIL stream_count got %0d exp 20", rx); else pass_cnt++;
    endtask

    task automatic test_exhaustion();
        bit acc;
        int idx = 0;
        int rx = 0;
        logic [16:0] w[12];
        foreach (w[i]) w[i] = 17'($urandom);
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            step(idx < 12, w[idx % 12], 0, acc);
            if (acc) idx++;
            if (o_valid === 1'b1) begin
                total++; if (o_data !== w[rx % 12]) $display("FAIL exhaust_order got %0h exp %0h", o_data, w[rx % 12]); else pass_cnt++;
                rx++;
            end
            total++; if (o_ready !== (m_q.size() < 2)) $display("FAIL exhaust_ready got %0b exp %0b", o_ready, m_q.size() < 2); else pass_cnt++;
        end
        total++; if (rx != 8) $display("FAIL exhaust_pulses got %0d exp 8", rx); else pass_cnt++;
        total++; if (o_credits !== 4'd0) $display("FAIL exhaust_credits got %0d exp 0", o_credits); else pass_cnt++;
        total++; if (o_ready !== 1'b0) $display("FAIL exhaust_full_ready got %0b exp 0", o_ready); else pass_cnt++;
        total++; if (idx != 10) $display("FAIL exhaust_accepted got %0d exp 10", idx); else pass_cnt++;
        step(0, '0, 1, acc);
        total++; if (o_valid !== 1'b0) $display("FAIL exhaust_return_valid got %0b exp 0", o_valid); else pass_cnt++;
        total++; if (o_credits !== 4'd1) $display("FAIL exhaust_return_credits got %0d exp 1", o_credits); else pass_cnt++;
        step(0, '0, 0, acc);
        total++; if (o_valid !== 1'b1) $display("FAIL exhaust_resume_valid got %0b exp 1", o_valid); else pass_cnt++;
        total++; if (o_data !== w[8]) $display("FAIL exhaust_resume_data got %0h exp %0h", o_data, w[8]); else pass_cnt++;
        total++; if (o_credits !== 4'd0) $display("FAIL exhaust_resume_credits got %0d exp 0", o_credits); else pass_cnt++;
        total++; if (o_ready !== 1'b1) $display("FAIL exhaust_reready got %0b exp 1", o_ready); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, acc);
            total++; if (o_valid !== 1'b0 || o_credits !== 4'd0) $display("FAIL exhaust_hold got valid %0b credits %0d exp 0 0", o_valid, o_credits); else pass_cnt++;
        end
    endtask

    task automatic test_simultaneous();
        bit acc;
        bit ok = 1'b0;
        int idx = 0;
        int s;
        logic [16:0] w[9];
        foreach (w[i]) w[i] = 17'($urandom);
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            if (m_cred == 1 && m_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            step(idx < 9, w[idx % 9], 0, acc);
            if (acc) idx++;
        end
        total++; if (!ok) $display("FAIL simul_setup got timeout exp credits 1 with data"); else pass_cnt++;
        s = idx - m_q.size();
        step(idx < 9, w[idx % 9], 1, acc);
        if (acc) idx++;
        total++; if (o_valid !== 1'b1) $display("FAIL simul_valid got %0b exp 1", o_valid); else pass_cnt++;
        total++; if (o_data !== w[s % 9]) $display("FAIL simul_data got %0h exp %0h", o_data, w[s % 9]); else pass_cnt++;
        total++; if (o_credits !== 4'd1) $display("FAIL simul_credits got %0d exp 1", o_credits); else pass_cnt++;
        step(0, '0, 0, acc);
        total++; if (o_valid !== 1'b1) $display("FAIL simul_next_valid got %0b exp 1", o_valid); else pass_cnt++;
        total++; if (o_data !== w[(s + 1) % 9]) $display("FAIL simul_next_data got %0h exp %0h", o_data, w[(s + 1) % 9]); else pass_cnt++;
        total++; if (o_credits !== 4'd0) $display("FAIL simul_next_credits got %0d exp 0", o_credits); else pass_cnt++;
    endtask

    task automatic test_overflow();
        bit acc;
        int idx = 0;
        int rx = 0;
        logic [16:0] w[3];
        foreach (w[i]) w[i] = 17'($urandom);
        apply_reset();
        step(0, '0, 0, acc);
        step(0, '0, 0, acc);
        total++; if (o_overflow !== 1'b0) $display("FAIL ovf_idle got %0b exp 0", o_overflow); else pass_cnt++;
        step(0, '0, 1, acc);
        total++; if (o_overflow !== 1'b1) $display("FAIL ovf_set got %0b exp 1", o_overflow); else pass_cnt++;
        total++; if (o_credits !== 4'd8) $display("FAIL ovf_credits got %0d exp 8", o_credits); else pass_cnt++;
        for (int c = 0; c < 20 && rx < 3; c++) begin
            step(idx < 3, w[idx % 3], 0, acc);
            if (acc) idx++;
            if (o_valid === 1'b1) begin
                total++; if (o_data !== w[rx]) $display("FAIL ovf_send_data got %0h exp %0h", o_data, w[rx]); else pass_cnt++;
                rx++;
            end
        end
        total++; if (rx != 3) $display("FAIL ovf_send_count got %0d exp 3", rx); else pass_cnt++;
        total++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", o_overflow); else pass_cnt++;
        total++; if (o_credits !== 4'd5) $display("FAIL ovf_after_credits got %0d exp 5", o_credits); else pass_cnt++;
    endtask

    task automatic test_midstream_reset();
        bit acc;
        int idx = 0;
        int rx = 0;
        logic [16:0] w[10];
        logic [16:0] n[4];
        foreach (w[i]) w[i] = 17'($urandom);
        foreach (n[i]) n[i] = 17'($urandom);
        apply_reset();
        for (int c = 0; c < 30 && rx < 5; c++) begin
            step(idx < 10, w[idx % 10], 0, acc);
            if (acc) idx++;
            if (o_valid === 1'b1) rx++;
        end
        total++; if (rx != 5) $display("FAIL mid_prefix got %0d exp 5", rx); else pass_cnt++;
        reset = 1'b0;
        step(1, w[idx % 10], 1, acc);
        total++; if (o_valid !== 1'b0 || o_credits !== 4'd8) $display("FAIL mid_reset got valid %0b credits %0d exp 0 8", o_valid, o_credits); else pass_cnt++;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 0, acc);
            total++; if (o_valid !== 1'b0) $display("FAIL mid_discard got %0b exp 0", o_valid); else pass_cnt++;
            total++; if (o_credits !== 4'd8) $display("FAIL mid_credits got %0d exp 8", o_credits); else pass_cnt++;
        end
        idx = 0;
        rx = 0;
        for (int c = 0; c < 20 && rx < 4; c++) begin
            step(idx < 4, n[idx % 4], 0, acc);
            if (acc) idx++;
            if (o_valid === 1'b1) begin
                total++; if (o_data !== n[rx]) $display("FAIL mid_new_data got %0h exp %0h", o_data, n[rx]); else pass_cnt++;
                rx++;
            end
            total++; if (o_credits !== 4'(m_cred)) $display("FAIL mid_new_credits got %0d exp %0d", o_credits, m_cred); else pass_cnt++;
        end
        total++; if (rx != 4) $display("FAIL mid_new_count got %0d exp 4", rx); else pass_cnt++;
        total++; if (o_credits !== 4'd4) $display("FAIL mid_final_credits got %0d exp 4", o_credits); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_exhaustion();
        test_simultaneous();
        test_overflow();
        test_midstream_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
